// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared debugger run-control types and constants
package debug_pkg;

  localparam int          PC_W_DEF      = 9;
  localparam int          DRAIN_CYC_DEF = 4;
  localparam logic [31:0] BUBBLE        = 32'hF800_0000;
  localparam logic [5:0]  HALT_OP       = 6'h3F;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DRAIN,
    HALTED
  } dbg_state_t;

endpackage

// File: rtl/edge_det_pulse.sv
// rtl/edge_det_pulse.sv - single-cycle pulse on the rising edge of a level input
module edge_det_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  // Combinational so the pulse lands in the same cycle the level first rises.
  assign pulse = din & ~din_q;

endmodule

// File: rtl/fetch_control_if.sv
// rtl/fetch_control_if.sv - PC, next-PC select and debugger run control for the fetch stage
module fetch_control_if
  import debug_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inicio,
  input  logic            modo,
  input  logic            paso,
  input  logic            stall,
  input  logic            PCSrcD,
  input  logic [PC_W-1:0] PCBranchD,
  input  logic            JumpD,
  input  logic [PC_W-1:0] PCJumpD,
  input  logic [31:0]     imem_data,
  output logic [PC_W-3:0] imem_addr,
  output logic [31:0]     Instr,
  output logic [PC_W-1:0] PCPlus4F,
  output logic            pipe_en,
  output logic            halted,
  output logic [31:0]     ciclos,
  output logic [PC_W-1:0] pc_actual
);

  localparam int CNT_W = $clog2(DRAIN_CYC + 1);

  dbg_state_t      state, state_nx;
  logic [PC_W-1:0] pc, pc_plus4, pc_nx;
  logic [CNT_W-1:0] drain_cnt;
  logic            step_mode;
  logic            paso_pulse;
  logic            fetch_live, adv, halt_hit, restart;

  edge_det_pulse u_paso_edge (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (paso),
    .pulse (paso_pulse)
  );

  always_comb begin
    pipe_en    = 1'b0;
    fetch_live = (state == RUN) || (state == STEP);
    case (state)
      RUN:     pipe_en = 1'b1;
      STEP:    pipe_en = paso_pulse;
      DRAIN:   pipe_en = step_mode ? paso_pulse : 1'b1;
      default: pipe_en = 1'b0;
    endcase

    adv      = pipe_en & ~stall;
    // A redirect resolved in ID squashes the HALT word sitting in fetch.
    halt_hit = fetch_live & adv & ~PCSrcD & ~JumpD & (imem_data[31:26] == HALT_OP);
    restart  = inicio & ((state == IDLE) || (state == HALTED));

    pc_plus4 = pc + PC_W'(4);
    if (JumpD)       pc_nx = PCJumpD;
    else if (PCSrcD) pc_nx = PCBranchD;
    else             pc_nx = pc_plus4;

    state_nx = state;
    case (state)
      IDLE, HALTED: if (inicio) state_nx = modo ? STEP : RUN;
      RUN, STEP:    if (halt_hit) state_nx = DRAIN;
      DRAIN:        if (pipe_en && drain_cnt <= CNT_W'(1)) state_nx = HALTED;
      default:      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= '0;
      ciclos    <= '0;
      step_mode <= 1'b0;
      drain_cnt <= '0;
    end else begin
      if (restart) step_mode <= modo;

      if (state == HALTED && inicio)        pc <= '0;
      else if (fetch_live && adv && !halt_hit) pc <= pc_nx;

      if (state == HALTED && inicio) ciclos <= '0;
      else if (pipe_en)              ciclos <= ciclos + 32'd1;

      if (halt_hit)                      drain_cnt <= CNT_W'(DRAIN_CYC);
      else if (state == DRAIN && pipe_en) drain_cnt <= drain_cnt - CNT_W'(1);
    end
  end

  assign imem_addr = pc[PC_W-1:2];
  assign Instr     = fetch_live ? imem_data : BUBBLE;
  assign PCPlus4F  = pc_plus4;
  assign halted    = (state == HALTED);
  assign pc_actual = pc;

endmodule
